// File: rtl/joy_move_ctrl_pkg.sv
// Shared constants and types for the joystick movement datapath.
// Screen extents are also used by the hvsync generator.
package joy_move_ctrl_pkg;

  localparam int unsigned PosW   = 10;
  localparam int unsigned HMax   = 640;
  localparam int unsigned VMax   = 480;
  localparam int unsigned NumDir = 4;

  localparam logic [1:0] DirLeft  = 2'd0;
  localparam logic [1:0] DirRight = 2'd1;
  localparam logic [1:0] DirUp    = 2'd2;
  localparam logic [1:0] DirDown  = 2'd3;

  typedef logic [PosW-1:0] pos_t;

  typedef enum logic [1:0] {
    StIdle,
    StHold,
    StRepeat
  } joy_state_e;

  // First eligible direction at or after ptr; scanning from the far end lets the
  // nearest candidate overwrite the others.
  function automatic logic [1:0] rr_first(input logic [NumDir-1:0] elig,
                                          input logic [1:0]        ptr);
    logic [1:0] idx;
    logic [1:0] cand;
    idx = ptr;
    for (int i = NumDir - 1; i >= 0; i--) begin
      cand = ptr + 2'(i);
      if (elig[cand]) idx = cand;
    end
    return idx;
  endfunction

endpackage

// File: rtl/joy_move_ctrl_if.sv
// Joystick buttons, frame pulse and position outputs of the movement controller.
// master drives buttons/frame_start; slave is the controller itself.
interface joy_move_ctrl_if;
  import joy_move_ctrl_pkg::*;

  logic              left;
  logic              right;
  logic              up;
  logic              down;
  logic              frame_start;
  pos_t              joy_x;
  pos_t              joy_y;
  pos_t              player_x;
  pos_t              player_y;
  logic [NumDir-1:0] dir_grant;
  logic              moving;

  modport master (
    output left, right, up, down, frame_start,
    input  joy_x, joy_y, player_x, player_y, dir_grant, moving
  );

  modport slave (
    input  left, right, up, down, frame_start,
    output joy_x, joy_y, player_x, player_y, dir_grant, moving
  );

endinterface

// File: rtl/joy_debounce.sv
// Two-flop synchroniser followed by a tick-sampled debouncer for one button.
// The level flips only after DEB_TICKS consecutive disagreeing ticks.
module joy_debounce #(
  parameter int unsigned DEB_TICKS = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic tick_i,
  input  logic raw_i,
  output logic level_o
);

  localparam int unsigned CntW = $clog2(DEB_TICKS + 1);

  logic            sync1_q;
  logic            sync2_q;
  logic            level_q, level_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (tick_i) begin
      if (sync2_q == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == CntW'(DEB_TICKS - 1)) begin
        level_d = ~level_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/joy_move_ctrl.sv
// Joystick movement controller: debounced directions, round-robin arbitration,
// first-step / hold / auto-repeat sequencing, clamped position and frame latch.
module joy_move_ctrl
  import joy_move_ctrl_pkg::*;
#(
  parameter int unsigned H_MAX        = HMax,
  parameter int unsigned V_MAX        = VMax,
  parameter int unsigned TICK_DIV     = 250000,
  parameter int unsigned DEB_TICKS    = 3,
  parameter int unsigned REPEAT_DELAY = 20,
  parameter int unsigned X_INIT       = 320,
  parameter int unsigned Y_INIT       = 240
) (
  input logic            clk,
  input logic            reset,
  joy_move_ctrl_if.slave bus
);

  localparam int unsigned TickW = $clog2(TICK_DIV);
  localparam int unsigned HoldW = $clog2(REPEAT_DELAY + 2);

  logic [TickW-1:0]  tick_cnt_q, tick_cnt_d;
  logic              tick;
  logic [NumDir-1:0] raw;
  logic [NumDir-1:0] deb;
  logic [NumDir-1:0] elig;
  logic              any_elig;
  logic [1:0]        pick;
  logic              step;

  joy_state_e        state_q, state_d;
  logic [HoldW-1:0]  hold_q, hold_d;
  logic [1:0]        ptr_q, ptr_d;
  pos_t              x_q, x_d, y_q, y_d;
  pos_t              px_q, px_d, py_q, py_d;

  // Free-running movement tick, independent of the FSM.
  always_comb begin
    tick       = (tick_cnt_q == TickW'(TICK_DIV - 1));
    tick_cnt_d = tick ? '0 : tick_cnt_q + TickW'(1);
  end

  assign raw = {bus.down, bus.up, bus.right, bus.left};

  for (genvar g = 0; g < NumDir; g++) begin : g_deb
    joy_debounce #(
      .DEB_TICKS(DEB_TICKS)
    ) u_deb (
      .clk    (clk),
      .reset  (reset),
      .tick_i (tick),
      .raw_i  (raw[g]),
      .level_o(deb[g])
    );
  end

  // Opposing directions cancel; the range check doubles as the clamp.
  always_comb begin
    elig[DirLeft]  = deb[DirLeft] & ~deb[DirRight] & (x_q != '0);
    elig[DirRight] = deb[DirRight] & ~deb[DirLeft] & (x_q != PosW'(H_MAX - 1));
    elig[DirUp]    = deb[DirUp] & ~deb[DirDown] & (y_q != '0);
    elig[DirDown]  = deb[DirDown] & ~deb[DirUp] & (y_q != PosW'(V_MAX - 1));
    any_elig       = |elig;
    pick           = rr_first(elig, ptr_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_q <= '0;
      state_q    <= StIdle;
      hold_q     <= '0;
      ptr_q      <= DirLeft;
      x_q        <= PosW'(X_INIT);
      y_q        <= PosW'(Y_INIT);
      px_q       <= PosW'(X_INIT);
      py_q       <= PosW'(Y_INIT);
    end else begin
      tick_cnt_q <= tick_cnt_d;
      state_q    <= state_d;
      hold_q     <= hold_d;
      ptr_q      <= ptr_d;
      x_q        <= x_d;
      y_q        <= y_d;
      px_q       <= px_d;
      py_q       <= py_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    if (tick) begin
      unique case (state_q)
        StIdle: begin
          if (any_elig) begin
            hold_d  = HoldW'(REPEAT_DELAY);
            state_d = StHold;
          end
        end
        StHold: begin
          if (!any_elig) begin
            state_d = StIdle;
          end else begin
            hold_d = hold_q - HoldW'(1);
            if (hold_q <= HoldW'(1)) state_d = StRepeat;
          end
        end
        StRepeat: begin
          if (!any_elig) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    step = ~reset & tick & any_elig & ((state_q == StIdle) || (state_q == StRepeat));
    bus.dir_grant = '0;
    if (step) bus.dir_grant[pick] = 1'b1;
    bus.moving   = (state_q == StHold) || (state_q == StRepeat);
    bus.joy_x    = x_q;
    bus.joy_y    = y_q;
    bus.player_x = px_q;
    bus.player_y = py_q;
  end

  // Frame latch samples the pre-step position; a same-cycle step shows next frame.
  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    ptr_d = ptr_q;
    px_d  = bus.frame_start ? x_q : px_q;
    py_d  = bus.frame_start ? y_q : py_q;
    if (step) begin
      ptr_d = pick + 2'd1;
      unique case (pick)
        DirLeft:  x_d = x_q - PosW'(1);
        DirRight: x_d = x_q + PosW'(1);
        DirUp:    y_d = y_q - PosW'(1);
        DirDown:  y_d = y_q + PosW'(1);
        default:  x_d = x_q;
      endcase
    end
  end

endmodule

// File: tb/tb_joy_move_ctrl.sv
// Directed bench for joy_move_ctrl with a short tick so all sequencing is visible.
module tb_joy_move_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  joy_move_ctrl_if bus_a ();
  joy_move_ctrl_if bus_b ();

  joy_move_ctrl #(
    .TICK_DIV    (4),
    .DEB_TICKS   (2),
    .REPEAT_DELAY(3)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_a)
  );

  joy_move_ctrl #(
    .TICK_DIV    (4),
    .DEB_TICKS   (2),
    .REPEAT_DELAY(3),
    .X_INIT      (0)
  ) u_dut_x0 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_b)
  );

  // Cycle count since reset release; tick cycles are those with cyc % 4 == 3.
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_tick();
    do @(negedge clk); while (cyc % 4 != 3);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    {bus_a.left, bus_a.right, bus_a.up, bus_a.down, bus_a.frame_start} = '0;
    {bus_b.left, bus_b.right, bus_b.up, bus_b.down, bus_b.frame_start} = '0;

    // 1: reset state, idle inputs
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("t1_joy_x", bus_a.joy_x, 320);
    check_eq("t1_joy_y", bus_a.joy_y, 240);
    check_eq("t1_player_x", bus_a.player_x, 320);
    check_eq("t1_player_y", bus_a.player_y, 240);
    check_eq("t1_grant", bus_a.dir_grant, 0);
    check_eq("t1_moving", bus_a.moving, 0);
    check_eq("t1_x0_joy_x", bus_b.joy_x, 0);

    // 2: hold right -> first step, 3 hold ticks, repeat, release
    do_reset();
    wait_tick();
    bus_a.right = 1'b1;
    wait_tick(); check_eq("t2_deb_a", bus_a.dir_grant, 0);
    wait_tick(); check_eq("t2_deb_b", bus_a.dir_grant, 0);
    wait_tick();
    check_eq("t2_first_grant", bus_a.dir_grant, 4'b0010);
    check_eq("t2_first_pre", bus_a.joy_x, 320);
    @(negedge clk);
    check_eq("t2_first_x", bus_a.joy_x, 321);
    check_eq("t2_first_grant_off", bus_a.dir_grant, 0);
    check_eq("t2_moving", bus_a.moving, 1);
    for (int i = 0; i < 3; i++) begin
      wait_tick();
      check_eq("t2_hold_grant", bus_a.dir_grant, 0);
      check_eq("t2_hold_x", bus_a.joy_x, 321);
    end
    wait_tick(); check_eq("t2_rep_grant", bus_a.dir_grant, 4'b0010);
    @(negedge clk); check_eq("t2_rep_x1", bus_a.joy_x, 322);
    wait_tick(); @(negedge clk); check_eq("t2_rep_x2", bus_a.joy_x, 323);
    bus_a.right = 1'b0;
    wait_tick(); wait_tick(); @(negedge clk);
    check_eq("t2_rel_x", bus_a.joy_x, 325);
    check_eq("t2_rel_moving", bus_a.moving, 1);
    wait_tick();
    check_eq("t2_idle_grant", bus_a.dir_grant, 0);
    @(negedge clk);
    check_eq("t2_idle_moving", bus_a.moving, 0);
    check_eq("t2_idle_x", bus_a.joy_x, 325);

    // 3: left at x=0 is clamped
    do_reset();
    wait_tick();
    bus_b.left = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wait_tick();
      check_eq("t3_grant", bus_b.dir_grant, 0);
      check_eq("t3_moving", bus_b.moving, 0);
    end
    check_eq("t3_x", bus_b.joy_x, 0);
    bus_b.left = 1'b0;

    // 4: right+up alternate round-robin in repeat
    do_reset();
    wait_tick();
    bus_a.right = 1'b1;
    bus_a.up    = 1'b1;
    wait_tick(); wait_tick();
    wait_tick(); check_eq("t4_first", bus_a.dir_grant, 4'b0010);
    repeat (3) wait_tick();
    wait_tick(); check_eq("t4_g1", bus_a.dir_grant, 4'b0100);
    wait_tick(); check_eq("t4_g2", bus_a.dir_grant, 4'b0010);
    wait_tick(); check_eq("t4_g3", bus_a.dir_grant, 4'b0100);
    wait_tick(); check_eq("t4_g4", bus_a.dir_grant, 4'b0010);
    @(negedge clk);
    check_eq("t4_x", bus_a.joy_x, 323);
    check_eq("t4_y", bus_a.joy_y, 238);
    bus_a.right = 1'b0;
    bus_a.up    = 1'b0;

    // 5: left+right cancel, then right alone steps
    do_reset();
    wait_tick();
    bus_a.left  = 1'b1;
    bus_a.right = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_tick();
      check_eq("t5_cancel_grant", bus_a.dir_grant, 0);
    end
    check_eq("t5_cancel_moving", bus_a.moving, 0);
    check_eq("t5_cancel_x", bus_a.joy_x, 320);
    bus_a.left = 1'b0;
    wait_tick(); check_eq("t5_drop_a", bus_a.dir_grant, 0);
    wait_tick(); check_eq("t5_drop_b", bus_a.dir_grant, 0);
    wait_tick(); check_eq("t5_step", bus_a.dir_grant, 4'b0010);
    @(negedge clk);
    check_eq("t5_x", bus_a.joy_x, 321);
    check_eq("t5_moving", bus_a.moving, 1);
    bus_a.right = 1'b0;

    // 6: frame latch in a step cycle keeps the pre-step value
    do_reset();
    wait_tick();
    bus_a.right = 1'b1;
    repeat (3) wait_tick();
    repeat (3) wait_tick();
    wait_tick();
    check_eq("t6_step_grant", bus_a.dir_grant, 4'b0010);
    bus_a.frame_start = 1'b1;
    @(negedge clk);
    bus_a.frame_start = 1'b0;
    check_eq("t6_player_same", bus_a.player_x, 321);
    check_eq("t6_joy_same", bus_a.joy_x, 322);
    @(negedge clk);
    bus_a.frame_start = 1'b1;
    @(negedge clk);
    bus_a.frame_start = 1'b0;
    check_eq("t6_player_next", bus_a.player_x, 322);
    check_eq("t6_player_y", bus_a.player_y, 240);

    // 7: reset mid-repeat aborts, then re-debounce before stepping
    wait_tick();
    check_eq("t7_pre_grant", bus_a.dir_grant, 4'b0010);
    reset = 1'b1;
    @(negedge clk);
    check_eq("t7_joy_x", bus_a.joy_x, 320);
    check_eq("t7_player_x", bus_a.player_x, 320);
    check_eq("t7_grant", bus_a.dir_grant, 0);
    check_eq("t7_moving", bus_a.moving, 0);
    reset = 1'b0;
    wait_tick(); check_eq("t7_redeb_a", bus_a.dir_grant, 0);
    wait_tick(); check_eq("t7_redeb_b", bus_a.dir_grant, 0);
    check_eq("t7_redeb_x", bus_a.joy_x, 320);
    wait_tick(); check_eq("t7_step", bus_a.dir_grant, 4'b0010);
    @(negedge clk);
    check_eq("t7_x", bus_a.joy_x, 321);
    bus_a.right = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
